// File: rtl/scope_pkg.sv
// Shared types and constants for the scope capture path and the display readers.
// N_SAMPLES must match the data_display depth in draw_display.
package scope_pkg;

  localparam int N_SAMPLES = 256;
  localparam int DATA_W    = 12;
  localparam int IDX_W     = $clog2(N_SAMPLES);
  localparam int DECIM_W   = 4;

  typedef logic [DATA_W-1:0]  sample_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [DECIM_W-1:0] decim_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRIG,
    CAPTURE,
    COMMIT
  } cap_state_t;

  // Unsigned 12-bit level crossing between two consecutive valid samples.
  function automatic logic edge_hit(input sample_t prev, input sample_t cur,
                                    input sample_t level, input logic rising);
    logic rise_hit;
    logic fall_hit;
    rise_hit = (prev < level) && (cur >= level);
    fall_hit = (prev > level) && (cur <= level);
    return rising ? rise_hit : fall_hit;
  endfunction

endpackage

// File: rtl/scope_trigger_detect.sv
// Edge/level trigger with auto-mode timeout for the scope capture path.
// Only active while armed; disarming clears the seed sample, the timer and the force flag.
module scope_trigger_detect
  import scope_pkg::*;
#(
  parameter int AUTO_TIMEOUT = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                armed,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample,
  input  logic [DATA_W-1:0]   level,
  input  logic                rising,
  input  logic                auto_mode,
  output logic                trig
);

  localparam int TMR_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(AUTO_TIMEOUT - 1);

  sample_t          prev;
  logic             prev_valid;
  logic [TMR_W-1:0] tmr;
  logic             force_q;
  logic             level_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
    end else if (armed && sample_valid) begin
      prev <= sample;
    end
  end

  // Timer loads while disarmed so the first armed cycle sees AUTO_TIMEOUT-1;
  // reaching zero corresponds to cycle AUTO_TIMEOUT-1 after entry.
  always_ff @(posedge clk) begin
    if (rst || !armed) begin
      prev_valid <= 1'b0;
      tmr        <= TMR_LOAD;
      force_q    <= 1'b0;
    end else begin
      if (sample_valid) begin
        prev_valid <= 1'b1;
      end
      if (tmr != '0) begin
        tmr <= tmr - 1'b1;
      end else if (auto_mode) begin
        force_q <= 1'b1;
      end
    end
  end

  assign level_hit = prev_valid && edge_hit(prev, sample, level, rising);
  assign trig      = armed && sample_valid && (force_q || level_hit);

endmodule

// File: rtl/scope_capture.sv
// Writer side of the 256-sample scope display buffer: trigger, decimate, capture,
// then commit the whole frame to data_display on a vblnk rising edge only.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | stopped; waits for run
//   WAIT_TRIG | armed; trigger detector looks for an edge or auto timeout
//   CAPTURE   | filling cap_buf[1..255] with every (decim_q+1)-th sample
//   COMMIT    | frame complete; waits for vblnk rise to copy to display
module scope_capture
  import scope_pkg::*;
#(
  parameter int AUTO_TIMEOUT = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   adc_data,
  input  logic                adc_valid,
  input  logic                run,
  input  logic                auto_mode,
  input  logic [DATA_W-1:0]   trig_level,
  input  logic                trig_rising,
  input  logic [DECIM_W-1:0]  decim,
  input  logic                vblnk,
  output logic [DATA_W-1:0]   data_display [0:N_SAMPLES-1],
  output logic                busy,
  output logic                frame_ready
);

  localparam idx_t IDX_LAST = idx_t'(N_SAMPLES - 1);

  cap_state_t state;
  cap_state_t state_next;

  sample_t    cap_buf [0:N_SAMPLES-1];
  idx_t       idx;
  decim_t     dcnt;
  decim_t     decim_q;
  logic       vblnk_q;
  logic       vblnk_rise;
  logic       trig;
  logic       store;
  logic       commit_now;

  scope_trigger_detect #(
    .AUTO_TIMEOUT (AUTO_TIMEOUT)
  ) u_trig (
    .clk          (clk),
    .rst          (rst),
    .armed        (state == WAIT_TRIG),
    .sample_valid (adc_valid),
    .sample       (adc_data),
    .level        (trig_level),
    .rising       (trig_rising),
    .auto_mode    (auto_mode),
    .trig         (trig)
  );

  assign vblnk_rise = vblnk && !vblnk_q;
  assign store      = (state == CAPTURE) && adc_valid && (dcnt == decim_q);
  assign commit_now = (state == COMMIT) && vblnk_rise;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (run) state_next = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (trig) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (store && (idx == IDX_LAST)) state_next = COMMIT;
      end
      COMMIT: begin
        if (commit_now) state_next = run ? WAIT_TRIG : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // decim is sampled at the trigger so mid-frame changes cannot skew the timebase.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      dcnt        <= '0;
      decim_q     <= '0;
      vblnk_q     <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      vblnk_q     <= vblnk;
      frame_ready <= commit_now;
      if (trig) begin
        decim_q <= decim;
        idx     <= idx_t'(1);
        dcnt    <= '0;
      end else if ((state == CAPTURE) && adc_valid) begin
        if (dcnt == decim_q) begin
          dcnt <= '0;
          if (idx != IDX_LAST) idx <= idx + 1'b1;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end
  end

  // Capture buffer contents are never visible until a full frame is committed.
  always_ff @(posedge clk) begin
    if (trig) begin
      cap_buf[0] <= adc_data;
    end else if (store) begin
      cap_buf[idx] <= adc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        data_display[i] <= '0;
      end
    end else if (commit_now) begin
      data_display <= cap_buf;
    end
  end

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: trigger edges, decimation, auto timeout,
// tear-free commit, reset mid-capture and single-shot run.
`timescale 1ns/1ps
module tb_scope_capture;
  import scope_pkg::*;

  localparam int TMO = 100;

  logic               clk = 1'b0;
  logic               rst;
  logic [DATA_W-1:0]  adc_data;
  logic               adc_valid;
  logic               run;
  logic               auto_mode;
  logic [DATA_W-1:0]  trig_level;
  logic               trig_rising;
  logic [DECIM_W-1:0] decim;
  logic               vblnk;
  logic [DATA_W-1:0]  data_display [0:N_SAMPLES-1];
  logic               busy;
  logic               frame_ready;

  int n_checks = 0;
  int n_errors = 0;
  int fr_cnt   = 0;
  int fr_base;
  logic [DATA_W-1:0] v12;

  always #5 clk = ~clk;

  scope_capture #(.AUTO_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .run          (run),
    .auto_mode    (auto_mode),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .decim        (decim),
    .vblnk        (vblnk),
    .data_display (data_display),
    .busy         (busy),
    .frame_ready  (frame_ready)
  );

  always @(negedge clk) if (frame_ready === 1'b1) fr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    adc_data  = DATA_W'(v);
    adc_valid = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; run = 0; auto_mode = 0; trig_level = 0; trig_rising = 1;
    decim = 0; vblnk = 0; adc_data = 0; adc_valid = 0;
    repeat (3) step();
    rst = 0;
    step();
    check("rst_busy", busy, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_dd0", data_display[0], 0);
    check("rst_dd255", data_display[255], 0);

    // rising trigger, decim 0, ramp step 8
    trig_level = 12'd2048; trig_rising = 1; decim = 0; run = 1;
    step();
    check("arm_busy", busy, 1);
    for (int v = 0; v <= 4088; v += 8) feed(v);
    adc_valid = 0;
    repeat (4) step();
    check("rise_busy_commit", busy, 1);
    check("rise_no_early_dd0", data_display[0], 0);
    check("rise_no_early_fr", fr_cnt, 0);
    vblnk = 1;
    step();
    check("rise_fr", frame_ready, 1);
    check("rise_dd0", data_display[0], 2048);
    check("rise_dd1", data_display[1], 2056);
    check("rise_dd255", data_display[255], 4088);
    step();
    check("rise_fr_pulse", frame_ready, 0);
    check("rise_fr_cnt", fr_cnt, 1);
    vblnk = 0;
    step();

    // falling trigger, decim 3 (changed mid-capture), vblnk held high through completion
    trig_rising = 0; trig_level = 12'd1000; decim = 4'd3; vblnk = 1;
    v12 = 12'hFFF;
    for (int k = 0; k < 4116; k++) begin
      if (v12 == 12'd900) decim = 4'd0;
      feed(int'(v12));
      v12 = v12 - 12'd1;
    end
    adc_valid = 0;
    repeat (5) step();
    check("tear_busy", busy, 1);
    check("tear_hold_dd0", data_display[0], 2048);
    check("tear_hold_fr", fr_cnt, 1);
    vblnk = 0;
    repeat (5) step();
    check("tear_low_dd0", data_display[0], 2048);
    check("tear_low_dd255", data_display[255], 4088);
    check("tear_low_fr", fr_cnt, 1);
    vblnk = 1;
    step();
    check("fall_fr", frame_ready, 1);
    check("fall_dd0", data_display[0], 1000);
    check("fall_dd1", data_display[1], 996);
    check("fall_dd2", data_display[2], 992);
    check("fall_dd255", data_display[255], 4076);
    step();
    vblnk = 0;
    step();
    check("fall_fr_cnt", fr_cnt, 2);

    // no auto: constant below level never triggers
    trig_rising = 1; trig_level = 12'd2048; decim = 0; auto_mode = 0;
    for (int k = 0; k < 400; k++) feed(500);
    adc_valid = 0;
    step();
    check("noauto_busy", busy, 1);
    vblnk = 1;
    repeat (2) step();
    vblnk = 0;
    step();
    check("noauto_no_commit", fr_cnt, 2);

    // auto timeout: first valid at WAIT_TRIG cycle 100 is forced
    rst = 1;
    repeat (2) step();
    rst = 0; auto_mode = 1; run = 1;
    step();
    for (int k = 0; k < 400; k++) feed(k);
    adc_valid = 0;
    step();
    vblnk = 1;
    step();
    check("auto_fr", frame_ready, 1);
    check("auto_dd0", data_display[0], 100);
    check("auto_dd128", data_display[128], 228);
    check("auto_dd255", data_display[255], 355);
    vblnk = 0; auto_mode = 0;
    step();

    // reset mid-capture
    fr_base = fr_cnt;
    for (int v = 1800; v < 2400; v += 8) feed(v);
    adc_valid = 0;
    rst = 1; run = 0;
    repeat (2) step();
    check("midrst_dd0", data_display[0], 0);
    check("midrst_dd255", data_display[255], 0);
    check("midrst_busy", busy, 0);
    check("midrst_fr", frame_ready, 0);
    rst = 0;
    step();
    vblnk = 1;
    repeat (2) step();
    vblnk = 0;
    step();
    check("midrst_no_frame", fr_cnt, fr_base);

    // single shot with seed sample already above level
    run = 1;
    step();
    run = 0;
    check("shot_busy", busy, 1);
    feed(3000);
    feed(3000);
    feed(100);
    for (int v = 2100; v <= 2355; v++) feed(v);
    adc_valid = 0;
    step();
    check("shot_busy_commit", busy, 1);
    vblnk = 1;
    step();
    check("shot_fr", frame_ready, 1);
    check("shot_dd0", data_display[0], 2100);
    check("shot_dd255", data_display[255], 2355);
    step();
    vblnk = 0;
    step();
    check("shot_idle", busy, 0);
    fr_base = fr_cnt;
    for (int v = 0; v <= 4088; v += 8) feed(v);
    adc_valid = 0;
    vblnk = 1;
    repeat (2) step();
    vblnk = 0;
    step();
    check("shot_one_frame", fr_cnt, fr_base);
    check("shot_still_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
